// File: rtl/hmac_hash_checker.sv
// hmac_hash_checker: constant-time 256-bit HMAC compare with sticky tamper flag
module hmac_hash_checker #(
    parameter int MAX_FAIL = 3,
    parameter int CNT_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hash_valid_i,
    input  logic [255:0]     hash_i,
    input  logic [255:0]     expected_hash_i,
    input  logic             check_en_i,
    input  logic             clear_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             match_o,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             warning_o
);
    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_FAIL);
    state_t state_q, state_d;
    logic hv_q, diff_q, start, last, diff_now;
    logic [1:0] lane_q;
    logic [255:0] hash_q, exp_q;
    logic [CNT_W-1:0] cnt_inc;
    assign start    = (state_q == IDLE) && hash_valid_i && !hv_q && check_en_i;
    assign last     = (state_q == CMP) && (lane_q == 2'd3);
    // every lane is folded in, even after a difference is found
    assign diff_now = diff_q | (|(hash_q[{lane_q, 6'd0} +: 64] ^ exp_q[{lane_q, 6'd0} +: 64]));
    assign cnt_inc  = (fail_cnt_o == '1) ? fail_cnt_o : fail_cnt_o + 1'b1;
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE:    state_d = start ? CMP : IDLE;
            CMP: begin
                busy_o  = 1'b1;
                state_d = last ? RESP : CMP;
            end
            RESP: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            hv_q       <= 1'b0;
            lane_q     <= 2'd0;
            diff_q     <= 1'b0;
            hash_q     <= '0;
            exp_q      <= '0;
            match_o    <= 1'b0;
            mismatch_o <= 1'b0;
            fail_cnt_o <= '0;
            warning_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            hv_q    <= hash_valid_i;
            if (start) begin
                hash_q <= hash_i;
                exp_q  <= expected_hash_i;
                lane_q <= 2'd0;
                diff_q <= 1'b0;
            end else if (state_q == CMP) begin
                diff_q <= diff_now;
                lane_q <= lane_q + 2'd1;
            end else if (state_q == RESP) begin
                hash_q <= '0;
                exp_q  <= '0;
                diff_q <= 1'b0;
            end
            // clear wins over a result landing on the same edge
            if (clear_i) begin
                match_o    <= 1'b0;
                mismatch_o <= 1'b0;
                fail_cnt_o <= '0;
            end else if (last) begin
                match_o    <= !diff_now;
                mismatch_o <= diff_now;
                if (diff_now) begin
                    fail_cnt_o <= cnt_inc;
                    if (cnt_inc >= MAX_C) warning_o <= 1'b1;
                end
            end
        end
    end
endmodule
